// File: rtl/fetch_unit_pkg.sv
// definitions: shared fetch-unit constants, state type and branch-target table
package definitions;
  localparam int PC_W = 10;
  localparam int LUT_IDX_W = 3;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} fetch_state_t;
  localparam logic [PC_W-1:0] BR_TARGET [0:7] = '{
    10'd100, 10'd200, 10'd40, 10'd1023, 10'd17, 10'd500, 10'd7, 10'd900
  };
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_if: fetch-unit handshake and decoder feedback; cycle_count present with FETCH_CYCLE_CNT_EN
interface fetch_if #(
  parameter int PC_W = definitions::PC_W,
  parameter int LUT_IDX_W = definitions::LUT_IDX_W
);
  logic Start;
  logic Halt;
  logic branch_en;
  logic [LUT_IDX_W-1:0] branch_idx;
  logic [PC_W-1:0] PC;
  logic running;
  logic Ack;
`ifdef FETCH_CYCLE_CNT_EN
  logic [31:0] cycle_count;
  modport master(input Start, Halt, branch_en, branch_idx, output PC, running, Ack, cycle_count);
  modport slave(output Start, Halt, branch_en, branch_idx, input PC, running, Ack, cycle_count);
`else
  modport master(input Start, Halt, branch_en, branch_idx, output PC, running, Ack);
  modport slave(output Start, Halt, branch_en, branch_idx, input PC, running, Ack);
`endif
endinterface

// File: rtl/fetch_unit_branch_lut.sv
// branch_lut: branch_idx -> absolute target PC; undefined indices map to 0
module branch_lut #(
  parameter int PC_W = 10,
  parameter int LUT_IDX_W = 3
) (
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [PC_W-1:0]      target
);
  import definitions::*;
  logic [2:0] i;
  assign i = 3'(idx);
  assign target = (32'(idx) < 32'd8) ? PC_W'(BR_TARGET[i]) : '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer with Start/Ack handshake; FETCH_CYCLE_CNT_EN adds a saturating run-cycle counter
module fetch_unit #(
  parameter int PC_W = 10,
  parameter int LUT_IDX_W = 3,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input logic     Clk,
  input logic     Reset,
  fetch_if.master bus
);
  import definitions::*;
  fetch_state_t state;
  logic [PC_W-1:0] lut_pc;
  branch_lut #(.PC_W(PC_W), .LUT_IDX_W(LUT_IDX_W)) u_lut (.idx(bus.branch_idx), .target(lut_pc));
  // Start restarts from any state, so it is checked ahead of the per-state behaviour
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      bus.PC <= '0;
      bus.running <= 1'b0;
      bus.Ack <= 1'b0;
    end else if (bus.Start) begin
      state <= LOAD;
      bus.PC <= START_ADDR;
      bus.running <= 1'b0;
      bus.Ack <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          state <= RUN;
          bus.running <= 1'b1;
        end
        RUN: begin
          if (bus.Halt) begin
            state <= DONE;
            bus.running <= 1'b0;
            bus.Ack <= 1'b1;
          end else begin
            bus.PC <= bus.branch_en ? lut_pc : bus.PC + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
`ifdef FETCH_CYCLE_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset || bus.Start) bus.cycle_count <= '0;
    else if (state == RUN && !(&bus.cycle_count)) bus.cycle_count <= bus.cycle_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plan checks plus randomized run against a behavioural model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus();
  fetch_unit dut (.Clk(clk), .Reset(rst), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;
  int tbl [8] = '{100, 200, 40, 1023, 17, 500, 7, 900};

  // model: which phase the program is in, expressed as plain flags
  int m_pc = 0;
  bit m_loading = 0, m_active = 0, m_ack = 0;
  longint m_cnt = 0;

  task automatic check(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0; m_loading = 0; m_active = 0; m_ack = 0; m_cnt = 0;
    end else if (bus.Start) begin
      m_pc = 0; m_loading = 1; m_active = 0; m_ack = 0; m_cnt = 0;
    end else if (m_loading) begin
      m_loading = 0; m_active = 1;
    end else if (m_active) begin
      m_cnt = (m_cnt == 64'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
      if (bus.Halt) begin
        m_active = 0; m_ack = 1;
      end else if (bus.branch_en) m_pc = tbl[bus.branch_idx];
      else m_pc = (m_pc + 1) % 1024;
    end
  end

  always @(negedge clk) begin
    check("pc", bus.PC, m_pc);
    check("running", bus.running, m_active);
    check("ack", bus.Ack, m_ack);
    check("run_ack_exclusive", bus.running & bus.Ack, 0);
`ifdef FETCH_CYCLE_CNT_EN
    check("cycle_count", bus.cycle_count, m_cnt);
`endif
  end

  task automatic step(bit s, bit h, bit b, int idx);
    bus.Start = s;
    bus.Halt = h;
    bus.branch_en = b;
    bus.branch_idx = 3'(idx);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1;
    step(1, 0, 0, 0);
    check("reset_pc", bus.PC, 0); check("reset_running", bus.running, 0); check("reset_ack", bus.Ack, 0);
    step(1, 0, 0, 0);
    check("reset_pc2", bus.PC, 0); check("reset_ack2", bus.Ack, 0);
    rst = 0;
    step(1, 0, 0, 0);
    check("load_pc", bus.PC, 0); check("load_running", bus.running, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("run_first_pc", bus.PC, 0); check("run_first_running", bus.running, 1);
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 0, 0);
      check("seq_pc", bus.PC, k);
    end
    step(1, 0, 0, 0);
    check("restart_pc", bus.PC, 0); check("restart_running", bus.running, 0);
    step(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
    check("pre_branch_pc", bus.PC, 3);
    step(0, 0, 1, 2);
    check("branch_pc", bus.PC, 40);
    step(0, 0, 0, 0);
    check("after_branch_pc", bus.PC, 41);
    step(0, 1, 1, 2);
    check("halt_pc", bus.PC, 41); check("halt_ack", bus.Ack, 1); check("halt_running", bus.running, 0);
    step(0, 1, 1, 3);
    check("done_hold_pc", bus.PC, 41); check("done_hold_ack", bus.Ack, 1);
    step(1, 0, 0, 0);
    check("done_start_ack", bus.Ack, 0); check("done_start_pc", bus.PC, 0);
`ifdef FETCH_CYCLE_CNT_EN
    check("cnt_load", bus.cycle_count, 0);
`endif
    step(0, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0);
    check("count_run_pc", bus.PC, 6);
    step(0, 1, 0, 0);
    check("count_halt_pc", bus.PC, 6); check("count_halt_ack", bus.Ack, 1);
`ifdef FETCH_CYCLE_CNT_EN
    check("cnt_done", bus.cycle_count, 7);
    step(0, 0, 0, 0);
    check("cnt_hold", bus.cycle_count, 7);
`endif
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 3);
    check("wrap_pre_pc", bus.PC, 1023);
    step(0, 0, 0, 0);
    check("wrap_pc", bus.PC, 0); check("wrap_running", bus.running, 1);
    step(0, 0, 1, 4);
    check("pc17", bus.PC, 17);
    step(1, 0, 0, 0);
    check("abort_pc", bus.PC, 0); check("abort_running", bus.running, 0);
    step(0, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 999));
      rst = (r < 5);
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 25, int'($urandom_range(0, 7)));
    end
    rst = 0;
    step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch sequencer feeding the instruction ROM.
- The ROM word at `PC` goes combinationally to the control decoder. The decoder's `branch_en` comes back here and selects the next `PC`.
- Absolute branch targets come from a small lookup table indexed by an instruction field.
- Start/Ack handshake with the testbench/top level: run a program, report completion.

Parameters:
- `PC_W`, 10, width of the program counter (1024-entry instruction ROM).
- `LUT_IDX_W`, 3, width of the branch-target index (8 targets).
- `START_ADDR`, 0, `PC` value loaded on `Start`.

Ports:
- `Clk`  in  1  system clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  level request; while high, the unit is held at `START_ADDR`; program runs after it falls.
- `Halt`  in  1  decoded halt instruction at the current `PC` (combinational from the decoder).
- `branch_en`  in  1  taken-branch indication for the instruction at the current `PC`.
- `branch_idx`  in  `LUT_IDX_W`  target-table index from the current instruction, low bits.
- `PC`  out  `PC_W`  address presented to the instruction ROM.
- `running`  out  1  high while instructions are being executed.
- `Ack`  out  1  high once the program has halted; held until the next `Start`.

Behaviour:
- One clock domain. All state updates happen on the rising edge of `Clk`. Reset is synchronous and active-high.
- Reset: `PC` = 0, state `IDLE`, `running` = 0, `Ack` = 0. `Reset` overrides every other input, including mid-program. A reset in `RUN` or `DONE` returns to `IDLE` on that edge.
- States (`fetch_state_t`): `IDLE`, `LOAD`, `RUN`, `DONE`.
- `IDLE`: `PC` holds. If `Start` = 1, go to `LOAD`, with `PC` <= `START_ADDR` and `Ack` <= 0.
- `LOAD`: `PC` = `START_ADDR`, `running` = 0. Stay while `Start` = 1. When `Start` = 0, go to `RUN`; the first instruction executes in the first `RUN` cycle.
- `RUN`: `running` = 1. Next-`PC` priority, highest first:
  1. `Start` = 1: go to `LOAD`, `PC` <= `START_ADDR` (abort and restart).
  2. `Halt` = 1: go to `DONE`; `PC` holds at the halt address; `Ack` <= 1.
  3. `branch_en` = 1: `PC` <= `LUT[branch_idx]`.
  4. Otherwise: `PC` <= `PC` + 1.
- `DONE`: `running` = 0, `Ack` = 1, `PC` holds. `Start` = 1 goes to `LOAD` and clears `Ack` on that edge.
- Latency: `branch_en` and `Halt` are sampled combinationally in the same cycle as the instruction. The effect appears on `PC` one cycle later. There are no delay slots and no bubbles.
- Wrap-around: `PC` + 1 is computed modulo 2^`PC_W`; all-ones increments to 0 with no flag.
- `branch_en` with `Halt` simultaneously: halt wins; no branch is taken.
- `branch_en` and `Halt` are ignored outside `RUN`.
- `LUT` contents are constants from the package. An index with no defined entry returns 0.
- `running` and `Ack` are registered and never high together.

Optional Feature:
- Macro: `FETCH_CYCLE_CNT_EN`.
- Defined:
  - Adds output `cycle_count` (32 bits), cleared on `Reset` and on entry to `LOAD`.
  - Increments by 1 on every `RUN`-state edge, including the edge that enters `DONE`.
  - Saturates at all-ones.
  - Holds in `DONE` for readout.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package `definitions` gains:
  - `fetch_state_t` enum.
  - `PC_W` and `LUT_IDX_W` default constants.
  - Branch-target constant array `BR_TARGET[0:7]`.
- Sub-module `branch_lut`: combinational; `branch_idx` -> target `PC`, reads `BR_TARGET`.
- `fetch_unit` instantiates `branch_lut` once; the state machine and `PC` register live in `fetch_unit`.

Test Plan:
- Reset: `Reset` = 1 for 2 cycles while `Start` = 1, then release -> `PC` = 0, `running` = 0, `Ack` = 0 during reset. `LOAD` is entered on the first edge after release.
- Sequential fetch: `Start` pulse 3 cycles with `START_ADDR` = 0; no branch/halt for 5 cycles -> `PC` goes 0,1,2,3,4,5; `running` = 1 from the first `RUN` cycle.
- Branch and priority: `BR_TARGET[2]` = 40.
  - At `PC` = 3 drive `branch_en` = 1, `branch_idx` = 2 -> next `PC` = 40, then 41.
  - At `PC` = 41 drive `branch_en` = 1 and `Halt` = 1 -> `PC` stays 41; `Ack` = 1 and `running` = 0 the next cycle.
- Wrap: load the `PC` path to 1023 via a branch entry, no branch -> next `PC` = 0; state stays `RUN`.
- Restart: `Start` = 1 while `PC` = 17 in `RUN` -> `PC` = `START_ADDR` next cycle. In `DONE`, `Start` clears `Ack` on the same edge; a new run proceeds from 0.
- `FETCH_CYCLE_CNT_EN`: run 0..5, then halt at 6 -> `cycle_count` = 7 held in `DONE`. Restart -> `cycle_count` = 0 during `LOAD`.
